// File: rtl/mpu_stream_tx.sv
// mpu_stream_tx: turns a raw MPU accelerometer stream into decimated gesture
// bursts. A large jump between consecutive raw samples starts a gesture of
// N_SAMPLES decimated samples. The block then waits for the recognizer result
// and holds mov low for a short gap before it can trigger again.
// Optional feature: define MPU_STREAM_TIMEOUT_EN to bound the result wait.
//
// state    | meaning
// IDLE     | tracking prev sample, looking for a trigger step
// STREAM   | sending every DECIM-th raw sample, mov high
// WAIT_RDY | all samples sent, waiting for res_ready, mov high
// GAP      | mov low for GAP_CYCLES cycles, raw input ignored
module mpu_stream_tx #(
  parameter int N_SAMPLES  = 30,
  parameter int DECIM      = 4,
  parameter int MOV_THRESH = 150,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_valid,
  input  logic signed [15:0] raw_accel,
  input  logic               res_ready,
  output logic signed [31:0] mpu_valor,
  output logic               mpu_valid,
  output logic               mov,
  output logic               busy,
  output logic               gesture_done,
  output logic               err_timeout
);

  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SAMPLES - 1);
  localparam logic [7:0]    DEC_LAST = 8'(DECIM - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RDY, GAP} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] prev_q, prev_d;
  logic               prev_ok_q, prev_ok_d;
  logic [7:0]         dec_q, dec_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               last_q, last_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic signed [31:0] valor_q, valor_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic signed [31:0] product, scaled, diff;
  logic [31:0]        mag;
  logic [IW-1:0]      idx_nxt;

  // 16384 LSB/g to x100 m/s^2: multiply by 981, floor-divide by 2^14
  assign product = $signed({{16{raw_accel[15]}}, raw_accel}) * 32'sd981;
  assign scaled  = product >>> 14;
  assign diff    = scaled - prev_q;
  assign mag     = diff[31] ? 32'(-diff) : 32'(diff);
  assign idx_nxt = idx_q + IW'(1);

`ifdef MPU_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          tmo_q, tmo_d;
`endif

  // Next-state and datapath decisions for the gesture sequencer
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    dec_d     = dec_q;
    idx_d     = idx_q;
    last_d    = last_q;
    gap_d     = gap_q;
    valor_d   = valor_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
`ifdef MPU_STREAM_TIMEOUT_EN
    wait_d    = wait_q;
    tmo_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (raw_valid) begin
          prev_d    = scaled;
          prev_ok_d = 1'b1;
          if (prev_ok_q && (mag >= 32'(MOV_THRESH))) begin
            state_d = STREAM;
            valid_d = 1'b1;
            valor_d = scaled;
            dec_d   = '0;
            idx_d   = '0;
            last_d  = (IDX_LAST == '0);
          end
        end
      end
      STREAM: begin
        // last_q delays the WAIT_RDY move so it lands after the final strobe
        if (last_q) begin
          state_d = WAIT_RDY;
          last_d  = 1'b0;
`ifdef MPU_STREAM_TIMEOUT_EN
          wait_d  = TMO_LOAD;
`endif
        end else if (raw_valid) begin
          if (dec_q == DEC_LAST) begin
            dec_d   = '0;
            valid_d = 1'b1;
            valor_d = scaled;
            idx_d   = idx_nxt;
            last_d  = (idx_nxt == IDX_LAST);
          end else begin
            dec_d = dec_q + 8'd1;
          end
        end
      end
      WAIT_RDY: begin
        if (res_ready) begin
          done_d  = 1'b1;
          state_d = GAP;
          gap_d   = GAP_LOAD;
`ifdef MPU_STREAM_TIMEOUT_EN
        end else if (wait_q == '0) begin
          tmo_d   = 1'b1;
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          wait_d = wait_q - TW'(1);
`endif
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d   = IDLE;
          prev_ok_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      dec_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      valor_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      dec_q     <= dec_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      valor_q   <= valor_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

`ifdef MPU_STREAM_TIMEOUT_EN
  // Result-wait down-counter and timeout strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign mpu_valor    = valor_q;
  assign mpu_valid    = valid_q;
  assign gesture_done = done_q;
  // mov decodes straight from state so reset drops it without waiting a clock
  assign mov          = (state_q == STREAM) || (state_q == WAIT_RDY);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mpu_stream_tx.sv
// Bench for mpu_stream_tx: randomized raw streams checked against a
// gesture-level model (which raw samples must be sent, and their scaled value).
module tb_mpu_stream_tx;
  localparam int N    = 30;
  localparam int DEC  = 4;
  localparam int THR  = 150;
  localparam int GAPC = 4;
  localparam int TMO  = 50;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               raw_valid = 1'b0;
  logic signed [15:0] raw_accel = '0;
  logic               res_ready = 1'b0;
  logic signed [31:0] mpu_valor;
  logic               mpu_valid, mov, busy, gesture_done, err_timeout;

  int n_checks = 0;
  int n_pass = 0;
  int m_prev_raw = 0;
  bit m_prev_ok = 1'b0;

  always #5 clk = ~clk;

  mpu_stream_tx #(.N_SAMPLES(N), .DECIM(DEC), .MOV_THRESH(THR),
                  .GAP_CYCLES(GAPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .raw_valid(raw_valid), .raw_accel(raw_accel),
    .res_ready(res_ready), .mpu_valor(mpu_valor), .mpu_valid(mpu_valid),
    .mov(mov), .busy(busy), .gesture_done(gesture_done), .err_timeout(err_timeout)
  );

  // floor(raw * 981 / 16384) by integer division, not by shifting
  function automatic int ref_scale(input int raw);
    int p;
    p = raw * 981;
    if (p >= 0) return p / 16384;
    return -((-p + 16383) / 16384);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Walk the idle input to target in steps too small to trigger
  task automatic settle_to(input int target);
    int r;
    do begin
      if (!m_prev_ok || iabs(target - m_prev_raw) <= 2000) r = target;
      else r = m_prev_raw + ((target > m_prev_raw) ? 2000 : -2000);
      raw_valid = 1'b1; raw_accel = 16'(r); res_ready = 1'b0;
      @(negedge clk);
      raw_valid = 1'b0;
      n_checks++;
      if (mov !== 1'b0 || mpu_valid !== 1'b0)
        $display("FAIL settle_%0d: mov=%b valid=%b want 0 0", r, mov, mpu_valid);
      else n_pass++;
      m_prev_raw = r; m_prev_ok = 1'b1;
    end while (r != target);
  endtask

  task automatic run_gesture(input string name, input int base, input int trig,
                             input int exp_first, input int vpct, input int rdy_delay,
                             input int abort_at, input bit want_tmo);
    int sends, k, got, t, last_t, cur, post;
    bit ev;
    settle_to(base);
    raw_valid = 1'b1; raw_accel = 16'(trig);
    @(negedge clk);
    n_checks++;
    if (mpu_valid !== 1'b1 || mpu_valor !== exp_first || mov !== 1'b1)
      $display("FAIL %s_first: valid=%b valor=%0d mov=%b want 1 %0d 1",
               name, mpu_valid, mpu_valor, mov, exp_first);
    else n_pass++;
    got = 1; sends = 1; k = 0; t = 0; last_t = 0; cur = exp_first;
    while (got < N && t < 2000) begin
      raw_valid = ($urandom_range(99) < vpct);
      raw_accel = 16'($urandom);
      res_ready = ($urandom_range(7) == 0);
      ev = 1'b0;
      if (raw_valid && sends < N) begin
        k++;
        if (k % DEC == 0) begin
          ev = 1'b1; cur = ref_scale(int'(raw_accel)); sends++;
        end
      end
      @(negedge clk);
      t++;
      n_checks++;
      if (mpu_valid !== ev || mpu_valor !== cur || mov !== 1'b1)
        $display("FAIL %s_stream t=%0d: valid=%b valor=%0d mov=%b want %b %0d 1",
                 name, t, mpu_valid, mpu_valor, mov, ev, cur);
      else n_pass++;
      if (ev) begin
        got++;
        if (vpct == 100) begin
          n_checks++;
          if (t - last_t !== DEC)
            $display("FAIL %s_spacing: got %0d want %0d", name, t - last_t, DEC);
          else n_pass++;
        end
        last_t = t;
        if (abort_at > 0 && got == abort_at) begin
          #2 reset = 1'b1;
          #1;
          n_checks++;
          if (mov !== 1'b0 || mpu_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_abort: mov=%b valid=%b busy=%b want 0 0 0",
                     name, mov, mpu_valid, busy);
          else n_pass++;
          raw_valid = 1'b0; res_ready = 1'b0;
          @(negedge clk);
          reset = 1'b0; m_prev_ok = 1'b0;
          repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (gesture_done !== 1'b0 || busy !== 1'b0)
              $display("FAIL %s_after_abort: done=%b busy=%b want 0 0", name, gesture_done, busy);
            else n_pass++;
          end
          return;
        end
      end
    end
    n_checks++;
    if (got !== N) $display("FAIL %s_count: got %0d want %0d", name, got, N);
    else n_pass++;
    // WAIT_RDY: raw input and the first res_ready (still in STREAM) are ignored
    for (int i = 0; i < rdy_delay; i++) begin
      raw_valid = 1'b1; raw_accel = 16'($urandom); res_ready = (i == 0);
      @(negedge clk);
      n_checks++;
      if (mov !== 1'b1 || busy !== 1'b1 || mpu_valid !== 1'b0 || gesture_done !== 1'b0 ||
          err_timeout !== 1'b0 || mpu_valor !== cur)
        $display("FAIL %s_wait%0d: mov=%b busy=%b valid=%b done=%b err=%b valor=%0d want 1 1 0 0 0 %0d",
                 name, i, mov, busy, mpu_valid, gesture_done, err_timeout, mpu_valor, cur);
      else n_pass++;
    end
    raw_valid = 1'b0;
    if (want_tmo) begin
      res_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b1 || gesture_done !== 1'b0 || mov !== 1'b0)
        $display("FAIL %s_timeout: err=%b done=%b mov=%b want 1 0 0", name, err_timeout, gesture_done, mov);
      else n_pass++;
    end else begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_checks++;
      if (gesture_done !== 1'b1 || err_timeout !== 1'b0 || mov !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s_done: done=%b err=%b mov=%b busy=%b want 1 0 0 1",
                 name, gesture_done, err_timeout, mov, busy);
      else n_pass++;
    end
    for (int i = 1; i < GAPC; i++) begin
      raw_valid = 1'b1; raw_accel = (i % 2 == 1) ? 16'sd16384 : -16'sd16384;
      res_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || mov !== 1'b0 || mpu_valid !== 1'b0 || gesture_done !== 1'b0 ||
          err_timeout !== 1'b0)
        $display("FAIL %s_gap%0d: busy=%b mov=%b valid=%b done=%b err=%b want 1 0 0 0 0",
                 name, i, busy, mov, mpu_valid, gesture_done, err_timeout);
      else n_pass++;
    end
    raw_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mov !== 1'b0 || gesture_done !== 1'b0)
      $display("FAIL %s_gap_end: busy=%b mov=%b done=%b want 0 0 0", name, busy, mov, gesture_done);
    else n_pass++;
    // first idle sample after the gap must not trigger even if far from trig
    post = (ref_scale(trig) >= 0) ? -16384 : 16384;
    raw_valid = 1'b1; raw_accel = 16'(post);
    @(negedge clk);
    raw_valid = 1'b0;
    n_checks++;
    if (mov !== 1'b0 || mpu_valid !== 1'b0)
      $display("FAIL %s_prev_cleared: mov=%b valid=%b want 0 0", name, mov, mpu_valid);
    else n_pass++;
    m_prev_raw = post; m_prev_ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mpu_valor !== 32'sd0 || mpu_valid !== 1'b0 || mov !== 1'b0 || busy !== 1'b0 ||
        gesture_done !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL reset: valor=%0d valid=%b mov=%b busy=%b done=%b err=%b want all 0",
               mpu_valor, mpu_valid, mov, busy, gesture_done, err_timeout);
    else n_pass++;
    reset = 1'b0; m_prev_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_gesture();
    run_gesture("full", 0, 16384, 981, 100, 10, 0, 1'b0);
  endtask

  task automatic test_scaling();
    run_gesture("scale_neg", 0, -16384, -981, 70, 3, 0, 1'b0);
    run_gesture("scale_m1", 16384, -1, -1, 70, 2, 0, 1'b0);
    run_gesture("scale_p1", 16384, 1, 0, 70, 1, 0, 1'b0);
  endtask

  task automatic test_threshold();
    settle_to(0);
    raw_valid = 1'b1; raw_accel = 16'sd2490;
    @(negedge clk);
    raw_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mov !== 1'b0 || mpu_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL thr_below: mov=%b valid=%b busy=%b want 0 0 0", mov, mpu_valid, busy);
    else n_pass++;
    m_prev_raw = 2490; m_prev_ok = 1'b1;
    run_gesture("thr_at", 0, 2506, 150, 80, 5, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_gesture("abort", 0, 16384, 981, 100, 0, 12, 1'b0);
    run_gesture("restart", 0, -16384, -981, 100, 4, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int base, trig;
    logic signed [15:0] r;
    for (int g = 0; g < 4; g++) begin
      base = int'($urandom_range(20000)) - 10000;
      do begin
        r = 16'($urandom);
        trig = int'(r);
      end while (iabs(ref_scale(trig) - ref_scale(base)) < THR);
      run_gesture("rand", base, trig, ref_scale(trig), 50 + g * 15,
                  1 + int'($urandom_range(30)), 0, 1'b0);
    end
  endtask

  task automatic test_timeout();
`ifdef MPU_STREAM_TIMEOUT_EN
    run_gesture("tmo", 0, 16384, 981, 100, TMO, 0, 1'b1);
`else
    run_gesture("no_tmo", 0, 16384, 981, 100, 200, 0, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_full_gesture();
    test_scaling();
    test_threshold();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
